data_sync: RTL and testbench
============================

Name: data_sync

Overview:
- Multi-flop synchronizer for an N-bit data bus that crosses into the CLK domain.
- Only the single-bit qualifier bus_enable is synchronized, through a flop chain.
- A rising edge on the synchronized qualifier produces a one-cycle enable_pulse and captures unsync_bus into the registered sync_bus.
- Placed at the receiving side of every clock-domain crossing in the multi-clock system, for example the register-file and UART paths.

Parameters:
- BUS_WIDTH, default 8: width of unsync_bus and sync_bus; must be at least 1.
- NUM_STAGES, default 8: number of flops in the bus_enable synchronizer chain; must be at least 2.

Ports:
- CLK, input, 1: destination-domain clock; all state updates on its rising edge.
- RST, input, 1: asynchronous, active-low reset.
- unsync_bus, input, BUS_WIDTH: data from the source domain; the source holds it stable while bus_enable is asserted and through the synchronization window.
- bus_enable, input, 1: source-domain data-valid qualifier, asynchronous to CLK.
- sync_bus, output, BUS_WIDTH: registered synchronized data; holds its value between captures.
- enable_pulse, output, 1: registered one-CLK-cycle strobe, high in the cycle sync_bus first shows new data.

Behaviour:
- Reset (RST=0, asynchronous, no clock needed):
  - all synchronizer flops = 0
  - edge-detect flop = 0
  - sync_bus = 0
  - enable_pulse = 0
  - release is synchronous to the next CLK rising edge.
- Synchronizer chain: stage[0] <= bus_enable; stage[i] <= stage[i-1] for i = 1..NUM_STAGES-1. sync_en = stage[NUM_STAGES-1].
- Edge detect:
  - en_q <= sync_en
  - pulse_comb = sync_en & ~en_q.
- Outputs:
  - enable_pulse <= pulse_comb.
  - sync_bus <= unsync_bus when pulse_comb = 1, else holds.
  - Both are registered; no combinational path from any input to any output.
- Latency: if bus_enable is first sampled high at rising edge k, then enable_pulse = 1 and sync_bus = unsync_bus both take effect at edge k+NUM_STAGES (edge k+8 by default). enable_pulse drops at edge k+NUM_STAGES+1.
- bus_enable held high for several cycles: exactly one enable_pulse, for the rising edge only. No new pulse until bus_enable has been low at least one sampled cycle and then rises again.
- bus_enable high for a single cycle: exactly one enable_pulse.
- Back-to-back transfers: the low gap must be at least one sampled cycle, or the two are merged into one pulse.
- unsync_bus changing while pulse_comb = 0 has no effect on sync_bus.
- Reset asserted mid-synchronization: the in-flight transfer is discarded and no pulse is produced after reset release. Exception: bus_enable still high at release is treated as a new rising edge.
- Metastability:
  - Only bus_enable passes through the chain.
  - unsync_bus is sampled only under the synchronized qualifier, so no per-bit synchronization is used.

Decomposition:
- Shared package: default constants DATA_SYNC_BUS_WIDTH = 8 and DATA_SYNC_STAGES = 8; no typedefs needed.
- One sub-module, bit_sync_chain: a parameterized NUM_STAGES single-bit flop chain with asynchronous active-low reset to 0. It is reused by the other single-bit crossings (reset sync, flags).
- Edge detect and data capture stay in data_sync.

Test Plan:
- Reset: RST=0 for one cycle with bus_enable=0 -> sync_bus = 8'h00, enable_pulse = 0 during and after reset.
- Single transfer: unsync_bus = 8'hA2, bus_enable high for one cycle sampled at edge k -> at edge k+8, sync_bus = 8'hA2 and enable_pulse = 1. enable_pulse is 0 at every other edge.
- Sequential transfers 8'h55 then 8'hBC, each with a one-cycle enable and spaced 9 cycles apart -> each value appears on sync_bus with one pulse exactly 8 edges after its enable. sync_bus holds the value between captures.
- Level enable: bus_enable high for 5 cycles with data 8'h3C -> exactly one pulse at k+8, and sync_bus = 8'h3C.
- Data change without enable: after capturing 8'hA2, drive unsync_bus = 8'hFF with bus_enable = 0 for 20 cycles -> sync_bus stays 8'hA2, no pulse.
- Reset mid-flight: enable sampled at edge k, RST=0 at k+3 for one cycle with bus_enable low -> no pulse, and sync_bus = 8'h00 afterwards.

Source files
------------

// File: rtl/data_sync_pkg.sv
// rtl/data_sync_pkg.sv - shared defaults for the data_sync bus synchronizer
package data_sync_pkg;
  localparam int DATA_SYNC_BUS_WIDTH = 8;
  localparam int DATA_SYNC_STAGES    = 8;
endpackage

// File: rtl/bit_sync_chain.sv
// rtl/bit_sync_chain.sv - single-bit multi-flop synchronizer chain, async active-low reset to 0
import data_sync_pkg::*;

module bit_sync_chain #(
  parameter int NUM_STAGES = DATA_SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [NUM_STAGES-1:0] r_stages;

  // stage 0 takes the asynchronous input; later stages only resolve metastability
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stages <= '0;
    end else begin
      r_stages <= {r_stages[NUM_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_stages[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// rtl/data_sync.sv - bus synchronizer: qualifier through a flop chain, data captured on its rising edge
import data_sync_pkg::*;

module data_sync #(
  parameter int BUS_WIDTH  = DATA_SYNC_BUS_WIDTH,
  parameter int NUM_STAGES = DATA_SYNC_STAGES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
);

  logic                 w_sync_en;
  logic                 w_pulse;
  logic                 r_en_q;
  logic                 r_enable_pulse;
  logic [BUS_WIDTH-1:0] r_sync_bus;

  bit_sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_en_sync (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_async (bus_enable),
    .o_sync  (w_sync_en)
  );

  assign w_pulse = w_sync_en & ~r_en_q;

  // data is stable by the time the qualifier clears the chain, so no per-bit sync is needed
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_en_q         <= 1'b0;
      r_enable_pulse <= 1'b0;
      r_sync_bus     <= '0;
    end else begin
      r_en_q         <= w_sync_en;
      r_enable_pulse <= w_pulse;
      if (w_pulse) begin
        r_sync_bus <= unsync_bus;
      end
    end
  end

  assign sync_bus     = r_sync_bus;
  assign enable_pulse = r_enable_pulse;

endmodule

// File: tb/tb_data_sync.sv
// tb/tb_data_sync.sv - scoreboard bench for data_sync
module tb_data_sync;

  localparam int W      = 8;
  localparam int STAGES = 8;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] unsync_bus = '0;
  logic         bus_enable = 1'b0;
  logic [W-1:0] sync_bus;
  logic         enable_pulse;

  exp_t         q[$];
  logic [W-1:0] exp_bus = '0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  data_sync #(.BUS_WIDTH(W), .NUM_STAGES(STAGES)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .unsync_bus   (unsync_bus),
    .bus_enable   (bus_enable),
    .sync_bus     (sync_bus),
    .enable_pulse (enable_pulse)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // per-edge monitor: pulse and bus compared against the scoreboard schedule
  always @(posedge CLK) begin
    logic exp_pulse;
    cyc = cyc + 1;
    #1;
    exp_pulse = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_pulse = 1'b1;
      exp_bus   = q[0].data;
      void'(q.pop_front());
    end
    check("enable_pulse", {31'd0, enable_pulse}, {31'd0, exp_pulse});
    check("sync_bus", {24'd0, sync_bus}, {24'd0, exp_bus});
  end

  task automatic step(input logic en, input logic [W-1:0] d);
    @(negedge CLK);
    if (en && !bus_enable) q.push_back('{cyc + 1 + STAGES, d});
    bus_enable = en;
    unsync_bus = d;
  endtask

  task automatic idle(input int n, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) step(1'b0, d);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_bus", {24'd0, sync_bus}, 32'd0);
    check("rst_pulse", {31'd0, enable_pulse}, 32'd0);
    RST = 1'b1;
    idle(3, 8'h00);

    // single one-cycle transfer
    step(1'b1, 8'hA2);
    idle(12, 8'hA2);

    // two transfers spaced 9 cycles
    step(1'b1, 8'h55);
    idle(8, 8'h55);
    step(1'b1, 8'hBC);
    idle(12, 8'hBC);

    // level enable for 5 cycles
    for (int i = 0; i < 5; i++) step(1'b1, 8'h3C);
    idle(12, 8'h3C);

    // capture then change data without enable
    step(1'b1, 8'hA2);
    idle(10, 8'hA2);
    idle(20, 8'hFF);

    // minimum one-cycle gap gives two pulses
    step(1'b1, 8'h11);
    step(1'b0, 8'h11);
    step(1'b1, 8'h11);
    idle(12, 8'h11);

    // reset mid-flight with enable low
    step(1'b1, 8'h77);
    step(1'b0, 8'h77);
    step(1'b0, 8'h77);
    @(negedge CLK);
    RST = 1'b0;
    q.delete();
    exp_bus = '0;
    #1;
    check("mid_rst_bus", {24'd0, sync_bus}, 32'd0);
    check("mid_rst_pulse", {31'd0, enable_pulse}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    idle(15, 8'h77);

    // enable still high at reset release counts as a new rising edge
    @(negedge CLK);
    bus_enable = 1'b1;
    unsync_bus = 8'hC3;
    RST = 1'b0;
    q.delete();
    exp_bus = '0;
    @(negedge CLK);
    RST = 1'b1;
    q.push_back('{cyc + 1 + STAGES, 8'hC3});
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC3);
    idle(12, 8'hC3);

    check("sb_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
